// File: rtl/module_mem_bus.sv
// Memory stage behind the CPU RAM port: 256x8 RAM, memory-mapped output register,
// and a valid/ready program loader that holds the CPU while it fills RAM.
module module_mem_bus #(
    parameter logic [7:0] IO_ADDR   = 8'hFF,
    parameter bit         IO_ENABLE = 1'b1
) (
    input  logic       clk_qzt,
    input  logic       reset,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_we,
    output logic [7:0] cpu_rdata,
    output logic [7:0] io_out,
    output logic       io_strobe,
    input  logic       load_start,
    input  logic [7:0] load_base,
    input  logic [7:0] load_len,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    output logic       ld_ready,
    output logic       cpu_hold,
    output logic       load_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] ptr_q, ptr_d;
    logic [8:0] cnt_q, cnt_d;
    logic       hold_q, hold_d;
    logic       ready_q, ready_d;
    logic [7:0] rdata_q;
    logic [7:0] io_out_q;
    logic       strobe_q;
    logic       we_old_q;

    logic [7:0] mem [256];

    logic io_hit;
    logic cpu_wr_en;
    logic ld_accept;

    assign io_hit    = IO_ENABLE && (cpu_addr == IO_ADDR);
    assign cpu_wr_en = (state_q == IDLE) && cpu_we;
    assign ld_accept = (state_q == LOAD) && ld_valid && ready_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        ready_d = ready_q;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    ptr_d   = load_base;
                    cnt_d   = (load_len == 8'd0) ? 9'd256 : {1'b0, load_len};
                    hold_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (ld_accept) begin
                    ptr_d = ptr_q + 8'd1;
                    cnt_d = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        ready_d = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                hold_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                hold_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_qzt or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 8'd0;
            cnt_q   <= 9'd0;
            hold_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            ready_q <= ready_d;
        end
    end

    // Single write port: loader and CPU are mutually exclusive because CPU writes need IDLE.
    always_ff @(posedge clk_qzt) begin
        if (ld_accept) begin
            mem[ptr_q] <= ld_data;
        end else if (cpu_wr_en && !io_hit) begin
            mem[cpu_addr] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk_qzt or posedge reset) begin
        if (reset) begin
            rdata_q  <= 8'd0;
            io_out_q <= 8'd0;
            strobe_q <= 1'b0;
            we_old_q <= 1'b0;
        end else begin
            rdata_q  <= io_hit ? io_out_q : mem[cpu_addr];
            we_old_q <= cpu_we;
            strobe_q <= cpu_wr_en && io_hit && !we_old_q;
            if (cpu_wr_en && io_hit) begin
                io_out_q <= cpu_wdata;
            end
        end
    end

    assign cpu_rdata = rdata_q;
    assign io_out    = io_out_q;
    assign io_strobe = strobe_q;
    assign ld_ready  = ready_q;
    assign cpu_hold  = hold_q;
    assign load_done = (state_q == DONE);

endmodule

// File: tb/tb_module_mem_bus.sv
// Self-checking bench for module_mem_bus: one instance with IO decode, one without,
// sharing all inputs; read results are checked through a scoreboard queue.
module tb_module_mem_bus;

    logic       clk;
    logic       reset;
    logic [7:0] cpu_addr, cpu_wdata;
    logic       cpu_we;
    logic       load_start;
    logic [7:0] load_base, load_len;
    logic       ld_valid;
    logic [7:0] ld_data;

    logic [7:0] cpu_rdata, io_out;
    logic       io_strobe, ld_ready, cpu_hold, load_done;
    logic [7:0] cpu_rdata0, io_out0;
    logic       io_strobe0, ld_ready0, cpu_hold0, load_done0;

    module_mem_bus #(.IO_ADDR(8'hFF), .IO_ENABLE(1'b1)) dut (
        .clk_qzt(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_rdata(cpu_rdata), .io_out(io_out), .io_strobe(io_strobe),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .cpu_hold(cpu_hold), .load_done(load_done)
    );

    module_mem_bus #(.IO_ADDR(8'hFF), .IO_ENABLE(1'b0)) dut0 (
        .clk_qzt(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_rdata(cpu_rdata0), .io_out(io_out0), .io_strobe(io_strobe0),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready0),
        .cpu_hold(cpu_hold0), .load_done(load_done0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] exp1;
        logic [7:0] exp0;
        bit         chk1;
        bit         chk0;
        string      tag;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] model1 [256];
    logic [7:0] model0 [256];
    logic [7:0] ioExp;
    int         errors = 0;
    int         checks = 0;

    function automatic logic [7:0] pat(input int i);
        return 8'((i + 1) * 17);
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_read(input logic [7:0] addr, input string tag);
        exp_t e;
        cpu_we   = 1'b0;
        cpu_addr = addr;
        e.tag  = tag;
        e.exp1 = (addr == 8'hFF) ? ioExp : model1[addr];
        e.exp0 = model0[addr];
        e.chk1 = !$isunknown(e.exp1);
        e.chk0 = !$isunknown(e.exp0);
        sbq.push_back(e);
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data, input int n);
        cpu_addr  = addr;
        cpu_wdata = data;
        cpu_we    = 1'b1;
        model0[addr] = data;
        if (addr == 8'hFF) ioExp = data;
        else model1[addr] = data;
        for (int i = 0; i < n; i++) cycle();
        cpu_we = 1'b0;
    endtask

    // Runs one load with the standard byte pattern; optionally disturbs it with
    // load_start or CPU writes that the design must ignore.
    task automatic drive_load(input logic [7:0] base, input logic [7:0] len, input bit gaps,
                              input bit disturbStart, input bit disturbWrite,
                              output int accepted, output int donePulses, output int holdDrops,
                              output int strobes, output int acceptedAtDone,
                              output logic holdStart, output logic readyStart,
                              output logic readyAtDone, output logic holdAfter,
                              output bit timedOut);
        int total;
        int post;
        bit doneSeen;
        logic [7:0] a;
        total = (len == 8'd0) ? 256 : int'(len);
        accepted = 0; donePulses = 0; holdDrops = 0; strobes = 0; acceptedAtDone = -1;
        readyAtDone = 1'bx; holdAfter = 1'bx; post = 0; doneSeen = 0;
        cpu_we = 1'b0; ld_valid = 1'b0;
        load_base = base; load_len = len; load_start = 1'b1;
        cycle();
        load_start = 1'b0;
        holdStart  = cpu_hold;
        readyStart = ld_ready;
        for (int k = 0; k < 1200 && post < 3; k++) begin
            ld_valid   = (accepted < total) && !(gaps && (k % 3 == 1));
            ld_data    = pat(accepted);
            load_start = 1'b0;
            load_base  = base;
            cpu_we     = 1'b0;
            if (disturbStart && accepted == 1) begin
                load_start = 1'b1;
                load_base  = 8'h80;
            end
            if (disturbWrite && accepted == 100) begin
                cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'hAB;
            end
            if (disturbWrite && accepted == 150) begin
                cpu_we = 1'b1; cpu_addr = 8'hFF; cpu_wdata = 8'h99;
            end
            if (ld_valid && ld_ready) begin
                a = base + 8'(accepted);
                model1[a] = ld_data;
                model0[a] = ld_data;
                accepted++;
            end
            cycle();
            if (io_strobe) strobes++;
            if (load_done) donePulses++;
            if (doneSeen) begin
                post++;
                if (post == 1) holdAfter = cpu_hold;
            end else if (load_done) begin
                doneSeen       = 1;
                acceptedAtDone = accepted;
                readyAtDone    = ld_ready;
            end else if (!cpu_hold) begin
                holdDrops++;
            end
        end
        ld_valid = 1'b0; cpu_we = 1'b0; load_start = 1'b0;
        timedOut = !doneSeen;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_addr = 8'h00; cpu_wdata = 8'h00; cpu_we = 1'b0;
        load_start = 1'b0; load_base = 8'h00; load_len = 8'h00;
        ld_valid = 1'b0; ld_data = 8'h00;
        ioExp = 8'h00;
        cycle(); cycle();
        checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_rdata: got %h want 00", cpu_rdata); end
        checks++; if (io_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_io_out: got %h want 00", io_out); end
        checks++; if (io_strobe !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobe: got %b want 0", io_strobe); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ld_ready: got %b want 0", ld_ready); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("[TB] FAIL reset_cpu_hold: got %b want 0", cpu_hold); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_done: got %b want 0", load_done); end
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_cpu_write_read();
        exp_t e;
        int strobes = 0;
        cpu_addr = 8'h10; cpu_wdata = 8'h5A; cpu_we = 1'b1;
        model1[8'h10] = 8'h5A; model0[8'h10] = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (io_strobe) strobes++;
        end
        cpu_we = 1'b0;
        checks++; if (strobes != 0) begin errors++; $display("[TB] FAIL ram_write_strobe: got %0d pulses want 0", strobes); end
        issue_read(8'h10, "read_10");
        cycle();
        e = sbq.pop_front();
        if (e.chk1) begin checks++; if (cpu_rdata !== e.exp1) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.tag, cpu_rdata, e.exp1); end end
        if (e.chk0) begin checks++; if (cpu_rdata0 !== e.exp0) begin errors++; $display("[TB] FAIL %s_noio: got %h want %h", e.tag, cpu_rdata0, e.exp0); end end
    endtask

    task automatic test_load_wrap();
        int acc, dp, hd, st, aad;
        logic hs, rs, rad, ha;
        bit to;
        exp_t e;
        logic [7:0] addrs [4] = '{8'hFE, 8'hFF, 8'h00, 8'h10};
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("[TB] FAIL wrap_hold_before: got %b want 0", cpu_hold); end
        drive_load(8'hFE, 8'd3, 1'b1, 1'b1, 1'b0, acc, dp, hd, st, aad, hs, rs, rad, ha, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL wrap_timeout: got no load_done want load_done"); end
        checks++; if (hs !== 1'b1) begin errors++; $display("[TB] FAIL wrap_hold_start: got %b want 1", hs); end
        checks++; if (rs !== 1'b1) begin errors++; $display("[TB] FAIL wrap_ready_start: got %b want 1", rs); end
        checks++; if (dp != 1) begin errors++; $display("[TB] FAIL wrap_done_pulses: got %0d want 1", dp); end
        checks++; if (aad != 3) begin errors++; $display("[TB] FAIL wrap_count_at_done: got %0d want 3", aad); end
        checks++; if (rad !== 1'b0) begin errors++; $display("[TB] FAIL wrap_ready_after_last: got %b want 0", rad); end
        checks++; if (hd != 0) begin errors++; $display("[TB] FAIL wrap_hold_drops: got %0d want 0", hd); end
        checks++; if (ha !== 1'b0) begin errors++; $display("[TB] FAIL wrap_hold_after: got %b want 0", ha); end
        checks++; if (st != 0 || io_out !== 8'h00) begin errors++; $display("[TB] FAIL wrap_io_untouched: got strobes=%0d io_out=%h want 0/00", st, io_out); end
        for (int i = 0; i < 4; i++) begin
            issue_read(addrs[i], $sformatf("wrap_read_%h", addrs[i]));
            cycle();
            e = sbq.pop_front();
            if (e.chk1) begin checks++; if (cpu_rdata !== e.exp1) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.tag, cpu_rdata, e.exp1); end end
            if (e.chk0) begin checks++; if (cpu_rdata0 !== e.exp0) begin errors++; $display("[TB] FAIL %s_noio: got %h want %h", e.tag, cpu_rdata0, e.exp0); end end
        end
    endtask

    task automatic test_io_write();
        int strobes = 0, strobes0 = 0;
        logic first;
        exp_t e;
        cpu_addr = 8'hFF; cpu_wdata = 8'hC3; cpu_we = 1'b1;
        ioExp = 8'hC3; model0[8'hFF] = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (i == 0) first = io_strobe;
            if (io_strobe) strobes++;
            if (io_strobe0) strobes0++;
        end
        cpu_we = 1'b0;
        cycle();
        if (io_strobe) strobes++;
        if (io_strobe0) strobes0++;
        checks++; if (io_out !== 8'hC3) begin errors++; $display("[TB] FAIL io_out: got %h want c3", io_out); end
        checks++; if (first !== 1'b1) begin errors++; $display("[TB] FAIL io_strobe_first: got %b want 1", first); end
        checks++; if (strobes != 1) begin errors++; $display("[TB] FAIL io_strobe_count: got %0d want 1", strobes); end
        checks++; if (io_out0 !== 8'h00) begin errors++; $display("[TB] FAIL noio_io_out: got %h want 00", io_out0); end
        checks++; if (strobes0 != 0) begin errors++; $display("[TB] FAIL noio_strobe_count: got %0d want 0", strobes0); end
        issue_read(8'hFF, "io_read_ff");
        cycle();
        e = sbq.pop_front();
        if (e.chk1) begin checks++; if (cpu_rdata !== e.exp1) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.tag, cpu_rdata, e.exp1); end end
        if (e.chk0) begin checks++; if (cpu_rdata0 !== e.exp0) begin errors++; $display("[TB] FAIL %s_noio: got %h want %h", e.tag, cpu_rdata0, e.exp0); end end
    endtask

    task automatic test_load_full();
        int acc, dp, hd, st, aad;
        logic hs, rs, rad, ha;
        bit to;
        exp_t e;
        logic [7:0] addrs [5] = '{8'h00, 8'h20, 8'h7F, 8'hFE, 8'hFF};
        drive_load(8'h00, 8'd0, 1'b1, 1'b0, 1'b1, acc, dp, hd, st, aad, hs, rs, rad, ha, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL full_timeout: got no load_done want load_done"); end
        checks++; if (aad != 256) begin errors++; $display("[TB] FAIL full_count_at_done: got %0d want 256", aad); end
        checks++; if (dp != 1) begin errors++; $display("[TB] FAIL full_done_pulses: got %0d want 1", dp); end
        checks++; if (hd != 0) begin errors++; $display("[TB] FAIL full_hold_drops: got %0d want 0", hd); end
        checks++; if (st != 0) begin errors++; $display("[TB] FAIL full_strobe: got %0d want 0", st); end
        checks++; if (io_out !== ioExp) begin errors++; $display("[TB] FAIL full_io_out: got %h want %h", io_out, ioExp); end
        for (int i = 0; i < 5; i++) begin
            issue_read(addrs[i], $sformatf("full_read_%h", addrs[i]));
            cycle();
            e = sbq.pop_front();
            if (e.chk1) begin checks++; if (cpu_rdata !== e.exp1) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.tag, cpu_rdata, e.exp1); end end
            if (e.chk0) begin checks++; if (cpu_rdata0 !== e.exp0) begin errors++; $display("[TB] FAIL %s_noio: got %h want %h", e.tag, cpu_rdata0, e.exp0); end end
        end
    endtask

    task automatic test_read_during_write();
        exp_t e;
        logic [7:0] addrs [2] = '{8'h30, 8'hFF};
        logic [7:0] wdat  [2] = '{8'h77, 8'h5E};
        cpu_write(8'h30, 8'h01, 2);
        cycle();
        for (int i = 0; i < 2; i++) begin
            issue_read(addrs[i], $sformatf("rdw_old_%h", addrs[i]));
            cpu_we = 1'b1; cpu_wdata = wdat[i];
            model0[addrs[i]] = wdat[i];
            if (addrs[i] == 8'hFF) ioExp = wdat[i];
            else model1[addrs[i]] = wdat[i];
            cycle();
            e = sbq.pop_front();
            if (e.chk1) begin checks++; if (cpu_rdata !== e.exp1) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.tag, cpu_rdata, e.exp1); end end
            if (e.chk0) begin checks++; if (cpu_rdata0 !== e.exp0) begin errors++; $display("[TB] FAIL %s_noio: got %h want %h", e.tag, cpu_rdata0, e.exp0); end end
            issue_read(addrs[i], $sformatf("rdw_new_%h", addrs[i]));
            cycle();
            e = sbq.pop_front();
            if (e.chk1) begin checks++; if (cpu_rdata !== e.exp1) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.tag, cpu_rdata, e.exp1); end end
            if (e.chk0) begin checks++; if (cpu_rdata0 !== e.exp0) begin errors++; $display("[TB] FAIL %s_noio: got %h want %h", e.tag, cpu_rdata0, e.exp0); end end
        end
    endtask

    task automatic test_reset_abort();
        int dones = 0, holds = 0;
        exp_t e;
        logic [7:0] addrs [3] = '{8'h40, 8'h41, 8'h42};
        load_base = 8'h40; load_len = 8'd4; load_start = 1'b1;
        cycle();
        load_start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            ld_valid = 1'b1;
            ld_data  = 8'hA1 + 8'(b);
            checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready_%0d: got %b want 1", b, ld_ready); end
            if (ld_ready) begin
                model1[8'h40 + 8'(b)] = ld_data;
                model0[8'h40 + 8'(b)] = ld_data;
            end
            cycle();
        end
        ld_valid = 1'b0;
        reset = 1'b1;
        ioExp = 8'h00;
        #1;
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("[TB] FAIL abort_hold: got %b want 0", cpu_hold); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL abort_ready: got %b want 0", ld_ready); end
        checks++; if (io_out !== 8'h00) begin errors++; $display("[TB] FAIL abort_io_out: got %h want 00", io_out); end
        checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("[TB] FAIL abort_rdata: got %h want 00", cpu_rdata); end
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (load_done) dones++;
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (load_done) dones++;
            if (cpu_hold) holds++;
        end
        checks++; if (dones != 0) begin errors++; $display("[TB] FAIL abort_done_pulses: got %0d want 0", dones); end
        checks++; if (holds != 0) begin errors++; $display("[TB] FAIL abort_hold_after: got %0d want 0", holds); end
        for (int i = 0; i < 3; i++) begin
            issue_read(addrs[i], $sformatf("abort_read_%h", addrs[i]));
            cycle();
            e = sbq.pop_front();
            if (e.chk1) begin checks++; if (cpu_rdata !== e.exp1) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.tag, cpu_rdata, e.exp1); end end
            if (e.chk0) begin checks++; if (cpu_rdata0 !== e.exp0) begin errors++; $display("[TB] FAIL %s_noio: got %h want %h", e.tag, cpu_rdata0, e.exp0); end end
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write_read();
        test_load_wrap();
        test_io_write();
        test_load_full();
        test_read_during_write();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/module_mem_bus.md
Name: module_mem_bus

Overview:
- Memory stage directly downstream of the CPU's RAM interface: 256x8 single-clock RAM serving the CPU's address, write-data and write-enable bus, returning read data to the CPU's data input.
- Adds a memory-mapped output register at IO_ADDR.
- Adds a byte-stream program loader with valid/ready handshake. The loader writes a program image into RAM and asserts cpu_hold while active; the top level gates the CPU's en with cpu_hold.

Parameters:
- IO_ADDR, 8'hFF, address decoded as the output register instead of RAM for CPU accesses.
- IO_ENABLE, 1, 0 disables IO decode so IO_ADDR behaves as plain RAM.

Ports:
- clk_qzt  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- cpu_addr  input  8  CPU address bus.
- cpu_wdata  input  8  CPU write data.
- cpu_we  input  1  CPU write enable (level, may stay high for many clk_qzt cycles).
- cpu_rdata  output  8  registered read data to the CPU.
- io_out  output  8  memory-mapped output register.
- io_strobe  output  1  one-cycle pulse when io_out is newly written.
- load_start  input  1  starts a load (sampled in IDLE only).
- load_base  input  8  first RAM address of the load.
- load_len  input  8  byte count; 0 means 256.
- ld_valid  input  1  loader byte valid.
- ld_data  input  8  loader byte.
- ld_ready  output  1  loader byte accepted when ld_valid && ld_ready.
- cpu_hold  output  1  high while a load is in progress.
- load_done  output  1  one-cycle pulse at load completion.

Behaviour:
- Reset (async, immediate): cpu_rdata=0, io_out=0, io_strobe=0, ld_ready=0, cpu_hold=0, load_done=0, FSM=IDLE, internal pointer/count=0, we_old=0. RAM contents are not cleared.
- CPU read:
  - Every clk_qzt edge, cpu_rdata <= io_out if (IO_ENABLE && cpu_addr==IO_ADDR), else mem[cpu_addr].
  - Latency is exactly 1 clk_qzt; data is stable well before the CPU's next slave-clock state.
- Read-during-write to the same address returns the old value (read-before-write), for both RAM and io_out.
- CPU write, FSM==IDLE only:
  - While cpu_we=1, mem[cpu_addr] <= cpu_wdata every cycle. This is idempotent for a held level.
  - If the address decodes to IO, io_out <= cpu_wdata and RAM is not written.
  - io_strobe=1 for one cycle on the first cycle of a cpu_we rising edge (cpu_we && !we_old) to IO_ADDR only.
  - we_old tracks cpu_we every cycle.
- CPU writes while FSM!=IDLE are ignored (no RAM write, no io_strobe).
- Loader FSM, three states:
  - IDLE: ld_ready=0. On load_start: ptr<=load_base, cnt<=(load_len==0 ? 256 : load_len) (9-bit), cpu_hold<=1, go to LOAD.
  - LOAD: ld_ready=1 (registered, high from the first LOAD cycle). On ld_valid&&ld_ready: mem[ptr]<=ld_data, ptr<=ptr+1 (8-bit wrap, 8'hFF -> 8'h00), cnt<=cnt-1. If cnt==1 at accept, ld_ready<=0 and go to DONE. ld_valid without ld_ready has no effect.
  - DONE: load_done=1 for exactly this cycle, cpu_hold<=0, go to IDLE.
- Loader writes always target the RAM array, including IO_ADDR; io_out and io_strobe are never touched by the loader.
- load_start outside IDLE is ignored.
- The read port keeps operating during LOAD, so cpu_rdata reflects the RAM.
- Reset during LOAD aborts immediately: bytes already accepted remain in RAM; cpu_hold=0; no load_done pulse.

Test Plan:
- CPU write 8'h5A to 8'h10 (cpu_we high 4 cycles), then read 8'h10 -> cpu_rdata=8'h5A one cycle after the address; no io_strobe.
- CPU write 8'hC3 to 8'hFF with cpu_we high 5 cycles -> io_out=8'hC3, io_strobe high exactly 1 cycle, mem[8'hFF] unchanged; read 8'hFF -> 8'hC3. Repeat with IO_ENABLE=0 -> RAM written, io_out stays 0.
- load_start with load_base=8'hFE, load_len=3, bytes 11,22,33 with ld_valid gaps -> mem[FE]=11, mem[FF]=22, mem[00]=33 (wrap); cpu_hold high from the cycle after load_start until DONE; single load_done pulse; ld_ready low after the third accept.
- load_len=0 -> exactly 256 bytes accepted before load_done; a CPU write issued mid-load to 8'h20 is ignored.
- Assert reset after 2 of 4 bytes -> cpu_hold=0, ld_ready=0, io_out=0 immediately; the first 2 bytes are present in RAM; no load_done pulse.
- Simultaneous CPU write 8'h77 and read of 8'h30 (old value 8'h01) -> cpu_rdata=8'h01 that cycle, 8'h77 the next.
